// File: rtl/prach_delay_ctrl.sv
// Runtime-programmable sample-delay line for PRACH streams: delays accepted samples
// by D (0..MAX_DELAY) through a circular buffer sequenced IDLE -> FILL -> RUN.
module prach_delay_ctrl #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_DELAY = 64,
  parameter int unsigned AW        = $clog2(MAX_DELAY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW:0]      cfg_delay,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             cfg_err,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             locked
);

  localparam int unsigned DW = AW + 1;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] FILL = 2'b01;
  localparam logic [1:0] RUN  = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_addr;
  logic [DW-1:0]    fill_cnt;
  logic [DW-1:0]    d_q;
  logic [DW-1:0]    d_new;
  logic             accept;
  logic             wr_en;
  logic             fill_done;
  logic             over_max;
  logic [WIDTH-1:0] mem [MAX_DELAY];

  // Datapath decode; a delay of MAX_DELAY maps to offset 0, i.e. the slot being overwritten.
  always_comb begin
    accept    = cfg_valid && cfg_ready;
    over_max  = cfg_delay > DW'(MAX_DELAY);
    d_new     = over_max ? DW'(MAX_DELAY) : cfg_delay;
    wr_en     = din_valid && (state_q != IDLE);
    rd_addr   = wr_ptr - d_q[AW-1:0];
    fill_done = (state_q == FILL) && din_valid && (fill_cnt == d_q - DW'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (d_new == DW'(0)) ? RUN : FILL;
      FILL:    if (fill_done) state_d = RUN;
      RUN:     if (accept) state_d = (d_new == DW'(0)) ? RUN : FILL;
      default: state_d = IDLE;
    endcase
  end

  // Sample storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      fill_cnt   <= '0;
      d_q        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      cfg_err    <= 1'b0;
      cfg_ready  <= 1'b1;
      locked     <= 1'b0;
    end else begin
      cfg_err    <= accept && over_max;
      cfg_ready  <= (state_d != FILL);
      locked     <= (state_d == RUN);
      dout_valid <= (state_q == RUN) && din_valid;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (accept) begin
        d_q      <= d_new;
        fill_cnt <= '0;
      end else if ((state_q == FILL) && din_valid) begin
        fill_cnt <= fill_cnt + DW'(1);
      end
      // Old D is used here even when an accept lands in the same cycle.
      if ((state_q == RUN) && din_valid)
        dout <= (d_q == DW'(0)) ? din : mem[rd_addr];
    end
  end

endmodule
